ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
- AHB-Lite slave holding a word-organised SRAM array; it is the direct consumer of the RISC-V core's AHB-Lite master port (haddr/htrans/hwrite/hsize/hwdata) and returns hrdata/hready/hresp to it.
- Used as unified instruction/data memory behind the address decoder.
- Supports byte, halfword and word transfers with lane masking.
- Returns a two-cycle ERROR for out-of-range, misaligned or unsupported-size transfers.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of 2.
- WAIT_STATES, 1, wait cycles inserted per NONSEQ/SEQ transfer; used only when AHB_SLV_WAIT_EN is defined; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- hsel  input  1  slave select from the address decoder.
- haddr  input  32  byte address; only the low log2(DEPTH)+2 bits index the array.
- htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hwrite  input  1  1 = write.
- hsize  input  3  0 = byte, 1 = half, 2 = word; any other value is an error.
- hprot  input  4  accepted and ignored.
- hwdata  input  32  write data, valid in the data phase.
- hready  input  1  bus-level HREADY; an address phase is sampled only when it is high.
- hreadyout  output  1  this slave's ready.
- hresp  output  1  0 = OKAY, 1 = ERROR.
- hrdata  output  32  raw read word.

Behaviour:
- Reset values: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, all data-phase registers cleared. Array contents are not reset.
- Address-phase sample condition: hsel & hready & htrans[1]. On sample, register addr, size, write, and a computed err flag.
- err is set when any of the following holds:
  - addr[31:log2(DEPTH)+2] != 0;
  - hsize > 2;
  - hsize=1 with addr[0]=1;
  - hsize=2 with addr[1:0] != 0.
- IDLE or BUSY while selected gives a zero-wait OKAY, with no state change and no array access.
- FSM states: IDLE, DATA, ERR1, ERR2.
  - IDLE -> DATA: sampled and not err.
  - IDLE -> ERR1: sampled and err.
  - DATA: hreadyout=1 and hresp=0 in the zero-wait build. At the end of the data phase, if sampled again, go to DATA or ERR1; otherwise go to IDLE.
  - ERR1: hreadyout=0, hresp=1; always goes to ERR2.
  - ERR2: hreadyout=1, hresp=1; the next transfer may be sampled here, same rules as IDLE.
- Write commit: array written at the clock edge ending the data phase (hreadyout=1 in DATA).
- Write lane masking:
  - byte writes lane addr[1:0] from hwdata[8*lane+7:8*lane];
  - half writes lanes {addr[1],0} and {addr[1],1};
  - word writes all 4 lanes.
- Read: hrdata = array[addr_q word index], as the full 32-bit word, valid whenever hreadyout=1 in DATA.
  - Lane extraction and sign extension are the master's job; this slave does not use is_signed.
  - hrdata holds its last value outside DATA.
- Read-after-write to the same word in back-to-back transfers returns the new data, because the write commits before the following data phase.
- Errored transfers never modify the array.
- hrdata is 0 during ERR1 and ERR2.
- Pipelining: the next address phase overlaps the current data phase. The registered address is never overwritten while hreadyout=0.
- Reset mid-transfer: the FSM returns to IDLE immediately and a pending write is dropped.

Optional Feature:
- Macro AHB_SLV_WAIT_EN.
- Defined:
  - adds state WAIT and a 4-bit counter;
  - a valid sample with WAIT_STATES > 0 enters WAIT with the counter set to WAIT_STATES-1, and hreadyout=0;
  - when the counter reaches 0, go to DATA, which completes with hreadyout=1;
  - WAIT_STATES=0 behaves exactly like the undefined case;
  - error transfers skip WAIT entirely.
- Undefined: no counter and no WAIT state; every valid transfer is zero-wait.

Decomposition:
- Package ahb_pkg holds:
  - htrans enum (IDLE, BUSY, NONSEQ, SEQ);
  - hsize constants (BYTE=0, HALF=1, WORD=2);
  - HRESP_OKAY and HRESP_ERROR;
  - the slave FSM state enum.
- One sub-module, ahb_sram_bytelane: a combinational write-strobe generator mapping (size, addr[1:0]) to a 4-bit byte enable. It is shared with future AHB slaves.

Test Plan:
- Word write 0xDEADBEEF to 0x10, then a word read at 0x10 -> hrdata=0xDEADBEEF, hresp=0, zero-wait (macro off).
- Byte write 0xAA to 0x13 over the stored 0xDEADBEEF, then a word read at 0x10 -> 0xAAADBEEF.
- Half write 0x1234 to 0x22, then a read -> upper half of word 0x20 = 0x1234, lower half unchanged.
- Word read at 0x0000_1000 with DEPTH=1024 -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1), array unchanged. Repeat with a misaligned word access at 0x02 -> same error sequence.
- Back-to-back NONSEQ write 0x5 to 0x40 then read 0x40 -> read returns 0x5; assert reset during a write data phase -> hreadyout=1, hresp=0, word unchanged.
- AHB_SLV_WAIT_EN with WAIT_STATES=2 -> read shows 2 cycles of hreadyout=0 then valid data; IDLE/BUSY transfers still get a zero-wait OKAY.

Source files
------------

// File: rtl/ahb_sram_slave_pkg.sv
// ahb_pkg: shared AHB-Lite encodings for the SRAM slave and its helpers.
//   htrans_e    - transfer type encoding (IDLE, BUSY, NONSEQ, SEQ)
//   HSIZE_*     - supported transfer sizes (byte, half, word)
//   HRESP_*     - response encoding
//   slv_state_e - slave data-phase FSM states; ST_WAIT exists only when
//                 AHB_SLV_WAIT_EN is defined.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_ERR1 = 3'd2,
    ST_ERR2 = 3'd3
`ifdef AHB_SLV_WAIT_EN
    ,
    ST_WAIT = 3'd4
`endif
  } slv_state_e;

endpackage

// File: rtl/ahb_sram_slave_if.sv
// ahb_sram_slave_if: AHB-Lite signal bundle between a master/interconnect
// and the SRAM slave.
//   master modport drives the address/data phase and bus-level hready;
//   slave modport returns hreadyout, hresp and hrdata.
interface ahb_sram_slave_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_bytelane.sv
// ahb_sram_bytelane: combinational AHB write-strobe generator.
//   size_i [2:0] - hsize of the transfer
//   addr_i [1:0] - low byte-address bits
//   be_o   [3:0] - byte enable per 8-bit lane; all zero for unsupported sizes
module ahb_sram_bytelane
  import ahb_pkg::*;
(
  input  logic [2:0] size_i,
  input  logic [1:0] addr_i,
  output logic [3:0] be_o
);

  always_comb begin
    be_o = 4'b0000;
    case (size_i)
      HSIZE_BYTE: be_o = 4'b0001 << addr_i;
      HSIZE_HALF: be_o = addr_i[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be_o = 4'b1111;
      default:    be_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite slave in front of a DEPTH x 32-bit word array.
//   clk   - system clock
//   reset - asynchronous active-low reset
//   bus   - ahb_sram_slave_if.slave (hsel/haddr/htrans/hwrite/hsize/hprot/
//           hwdata/hready in, hreadyout/hresp/hrdata out)
// Out-of-range, misaligned or unsupported-size transfers get a two-cycle
// ERROR and never touch the array.
// Optional: define AHB_SLV_WAIT_EN to insert WAIT_STATES wait cycles ahead
// of every valid data phase.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  ahb_sram_slave_if.slave   bus
);

  localparam int AW = $clog2(DEPTH) + 2;  // byte-address bits that index the array

  slv_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    size_q, size_d;
  logic          write_q, write_d;
  logic [31:0]   hrdata_q, hrdata_d;
`ifdef AHB_SLV_WAIT_EN
  logic [3:0]    cnt_q, cnt_d;
`endif

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata;
  logic [3:0]  be;
  logic        sample, addr_err, take, wr_en;

  assign sample = bus.hsel & bus.hready & bus.htrans[1];

  assign addr_err = (|bus.haddr[31:AW])
                  | (bus.hsize > HSIZE_WORD)
                  | ((bus.hsize == HSIZE_HALF) & bus.haddr[0])
                  | ((bus.hsize == HSIZE_WORD) & (|bus.haddr[1:0]));

  assign rdata = mem_q[addr_q[AW-1:2]];

  ahb_sram_bytelane u_bytelane (
    .size_i (size_q),
    .addr_i (addr_q[1:0]),
    .be_o   (be)
  );

  // DATA is always the completing cycle, so the write commits on its edge
  // and a read in the very next data phase already sees it.
  assign wr_en = (state_q == ST_DATA) & write_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[addr_q[AW-1:2]][8*b +: 8] <= bus.hwdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    size_d        = size_q;
    write_d       = write_q;
    hrdata_d      = hrdata_q;
`ifdef AHB_SLV_WAIT_EN
    cnt_d         = cnt_q;
`endif
    take          = 1'b0;
    bus.hreadyout = 1'b1;
    bus.hresp     = HRESP_OKAY;
    bus.hrdata    = hrdata_q;

    case (state_q)
      ST_DATA: begin
        bus.hrdata = rdata;
        hrdata_d   = rdata;
        take       = 1'b1;
      end
      ST_ERR1: begin
        bus.hreadyout = 1'b0;
        bus.hresp     = HRESP_ERROR;
        bus.hrdata    = '0;
        state_d       = ST_ERR2;
      end
      ST_ERR2: begin
        bus.hresp  = HRESP_ERROR;
        bus.hrdata = '0;
        take       = 1'b1;
      end
`ifdef AHB_SLV_WAIT_EN
      ST_WAIT: begin
        bus.hreadyout = 1'b0;
        if (cnt_q == 4'd0) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
`endif
      default: take = 1'b1;
    endcase

    // Only a completing cycle may accept the next address phase, so the
    // registered address is held stable while hreadyout is low.
    if (take) begin
      state_d = ST_IDLE;
      if (sample) begin
        addr_d  = bus.haddr[AW-1:0];
        size_d  = bus.hsize;
        write_d = bus.hwrite;
        if (addr_err) begin
          state_d = ST_ERR1;
        end else begin
          state_d = ST_DATA;
`ifdef AHB_SLV_WAIT_EN
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
      hrdata_q <= '0;
`ifdef AHB_SLV_WAIT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      write_q  <= write_d;
      hrdata_q <= hrdata_d;
`ifdef AHB_SLV_WAIT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // hprot carries no meaning for a plain SRAM.
  logic unused_ok;
`ifdef AHB_SLV_WAIT_EN
  assign unused_ok = ^bus.hprot;
`else
  assign unused_ok = ^{bus.hprot, 4'(WAIT_STATES)};
`endif

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: randomized + directed bench for ahb_sram_slave.
// A pipelined bus driver issues queued transfers; a byte-addressed memory
// model predicts read data, error responses and wait cycles.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  localparam int DEPTH = 1024;
  localparam int WS    = 2;
`ifdef AHB_SLV_WAIT_EN
  localparam int WEXP = WS;
`else
  localparam int WEXP = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;

  ahb_sram_slave_if bus ();

  ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Single slave: bus-level hready is this slave's hreadyout.
  assign bus.hready = bus.hreadyout;

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t       q[$];
  logic [31:0] mdl [DEPTH];
  bit          known [DEPTH];
  logic [31:0] last_rd;
  int          checks = 0;
  int          errors = 0;

  function automatic bit is_err(xfer_t x);
    int nb;
    if (x.size > 3'd2) return 1'b1;
    if (x.addr >= 32'(DEPTH * 4)) return 1'b1;
    nb = 1 << x.size;
    return (x.addr % nb) != 0;
  endfunction

  function automatic void mdl_write(xfer_t x);
    int nb, w, lane;
    nb = 1 << x.size;
    w  = int'(x.addr / 4);
    for (int i = 0; i < nb; i++) begin
      lane = int'((x.addr + 32'(i)) % 4);
      mdl[w][8*lane +: 8] = x.wdata[8*lane +: 8];
    end
    if (nb == 4) known[w] = 1'b1;
  endfunction

  function automatic xfer_t mk(logic sel, logic [1:0] tr, logic wr, logic [31:0] a,
                               logic [2:0] sz, logic [31:0] d);
    xfer_t x;
    x.sel = sel; x.trans = tr; x.wr = wr; x.addr = a; x.size = sz; x.wdata = d;
    return x;
  endfunction

  task automatic push(logic wr, logic [31:0] a, logic [2:0] sz, logic [31:0] d);
    q.push_back(mk(1'b1, HTRANS_NONSEQ, wr, a, sz, d));
  endtask

  task automatic drive_idle();
    bus.hsel = 1'b0; bus.htrans = HTRANS_IDLE; bus.hwrite = 1'b0;
    bus.haddr = '0; bus.hsize = '0; bus.hprot = '0; bus.hwdata = '0;
  endtask

  // Pipelined driver: address phase of the next transfer overlaps the data
  // phase of the current one and is held while hreadyout is low.
  task automatic run_q();
    xfer_t       ap, dp;
    bit          dp_vld = 1'b0;
    logic [31:0] exp_rd;
    dp = mk(0, HTRANS_IDLE, 0, 0, 0, 0);
    while (q.size() > 0 || dp_vld) begin
      ap = (q.size() > 0) ? q.pop_front() : mk(0, HTRANS_IDLE, 0, 0, 0, 0);
      bus.hsel = ap.sel; bus.htrans = ap.trans; bus.hwrite = ap.wr;
      bus.haddr = ap.addr; bus.hsize = ap.size; bus.hprot = 4'($urandom);
      bus.hwdata = dp_vld ? dp.wdata : $urandom;
      if (!dp_vld) begin
        @(negedge clk);
        checks++;
        if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0) begin
          errors++;
          $display("FAIL idle_okay: got rdy=%b resp=%b expected rdy=1 resp=0", bus.hreadyout, bus.hresp);
        end
      end else if (is_err(dp)) begin
        @(negedge clk);
        checks++;
        if ({bus.hreadyout, bus.hresp, bus.hrdata} !== {1'b0, 1'b1, 32'h0}) begin
          errors++;
          $display("FAIL err1 addr=%h size=%0d: got rdy=%b resp=%b rd=%h expected rdy=0 resp=1 rd=0",
                   dp.addr, dp.size, bus.hreadyout, bus.hresp, bus.hrdata);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({bus.hreadyout, bus.hresp, bus.hrdata} !== {1'b1, 1'b1, 32'h0}) begin
          errors++;
          $display("FAIL err2 addr=%h: got rdy=%b resp=%b rd=%h expected rdy=1 resp=1 rd=0",
                   dp.addr, bus.hreadyout, bus.hresp, bus.hrdata);
        end
      end else begin
        for (int i = 0; i < WEXP; i++) begin
          @(negedge clk);
          checks++;
          if (bus.hreadyout !== 1'b0 || bus.hresp !== 1'b0) begin
            errors++;
            $display("FAIL wait_cycle %0d: got rdy=%b resp=%b expected rdy=0 resp=0", i, bus.hreadyout, bus.hresp);
          end
          @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0) begin
          errors++;
          $display("FAIL data_okay addr=%h wr=%b: got rdy=%b resp=%b expected rdy=1 resp=0",
                   dp.addr, dp.wr, bus.hreadyout, bus.hresp);
        end
        if (!dp.wr) begin
          last_rd = bus.hrdata;
          exp_rd  = mdl[int'(dp.addr / 4)];
          if (known[int'(dp.addr / 4)]) begin
            checks++;
            if (bus.hrdata !== exp_rd) begin
              errors++;
              $display("FAIL read_data addr=%h: got %h expected %h", dp.addr, bus.hrdata, exp_rd);
            end
          end
        end
      end
      @(posedge clk);
      if (dp_vld && !is_err(dp) && dp.wr) mdl_write(dp);
      #1;
      dp     = ap;
      dp_vld = ap.sel && ap.trans[1];
    end
    drive_idle();
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.hreadyout, bus.hresp, bus.hrdata} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b resp=%b rd=%h expected rdy=1 resp=0 rd=0",
               bus.hreadyout, bus.hresp, bus.hrdata);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.hreadyout, bus.hresp, bus.hrdata} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL post_reset: got rdy=%b resp=%b rd=%h expected rdy=1 resp=0 rd=0",
               bus.hreadyout, bus.hresp, bus.hrdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_preload();
    for (int w = 0; w < 64; w++) push(1'b1, 32'(w * 4), HSIZE_WORD, $urandom);
    run_q();
  endtask

  task automatic test_word();
    push(1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF);
    push(1'b0, 32'h10, HSIZE_WORD, 32'h0);
    run_q();
    checks++;
    if (last_rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL word_rw: got %h expected deadbeef", last_rd);
    end
  endtask

  task automatic test_byte();
    push(1'b1, 32'h13, HSIZE_BYTE, 32'hAA00_0000);
    push(1'b0, 32'h10, HSIZE_WORD, 32'h0);
    run_q();
    checks++;
    if (last_rd !== 32'hAAADBEEF) begin
      errors++;
      $display("FAIL byte_lane: got %h expected aaadbeef", last_rd);
    end
  endtask

  task automatic test_half();
    push(1'b1, 32'h20, HSIZE_WORD, 32'h5566_7788);
    push(1'b1, 32'h22, HSIZE_HALF, 32'h1234_0000);
    push(1'b0, 32'h20, HSIZE_WORD, 32'h0);
    run_q();
    checks++;
    if (last_rd !== 32'h1234_7788) begin
      errors++;
      $display("FAIL half_lane: got %h expected 12347788", last_rd);
    end
  endtask

  task automatic test_err();
    logic [31:0] w0;
    w0 = mdl[0];
    push(1'b0, 32'h0000_1000, HSIZE_WORD, 32'h0);
    push(1'b1, 32'h0000_0002, HSIZE_WORD, 32'hFFFF_FFFF);
    push(1'b1, 32'h0000_0001, HSIZE_HALF, 32'hFFFF_FFFF);
    push(1'b1, 32'h0000_0000, 3'd3, 32'hFFFF_FFFF);
    push(1'b0, 32'h0000_0000, HSIZE_WORD, 32'h0);
    run_q();
    checks++;
    if (last_rd !== w0) begin
      errors++;
      $display("FAIL err_no_write: got %h expected %h", last_rd, w0);
    end
  endtask

  task automatic test_back_to_back();
    push(1'b1, 32'h40, HSIZE_WORD, 32'h5);
    q.push_back(mk(1'b1, HTRANS_SEQ, 1'b0, 32'h40, HSIZE_WORD, 32'h0));
    run_q();
    checks++;
    if (last_rd !== 32'h5) begin
      errors++;
      $display("FAIL raw_b2b: got %h expected 00000005", last_rd);
    end
  endtask

  task automatic test_reset_mid_write();
    bus.hsel = 1'b1; bus.htrans = HTRANS_NONSEQ; bus.hwrite = 1'b1;
    bus.haddr = 32'h40; bus.hsize = HSIZE_WORD;
    @(posedge clk); #1;
    drive_idle();
    bus.hwdata = 32'hFFFF_FFFF;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got rdy=%b resp=%b expected rdy=1 resp=0", bus.hreadyout, bus.hresp);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    push(1'b0, 32'h40, HSIZE_WORD, 32'h0);
    run_q();
    checks++;
    if (last_rd !== 32'h5) begin
      errors++;
      $display("FAIL reset_drop_write: got %h expected 00000005", last_rd);
    end
  endtask

  task automatic test_idle_busy();
    q.push_back(mk(1'b1, HTRANS_BUSY, 1'b1, 32'h10, HSIZE_WORD, 32'h0));
    q.push_back(mk(1'b1, HTRANS_IDLE, 1'b1, 32'h14, HSIZE_WORD, 32'h0));
    push(1'b0, 32'h10, HSIZE_WORD, 32'h0);
    q.push_back(mk(1'b1, HTRANS_BUSY, 1'b0, 32'h10, HSIZE_WORD, 32'h0));
    run_q();
  endtask

  task automatic test_random();
    xfer_t x;
    for (int n = 0; n < 300; n++) begin
      x.sel   = ($urandom_range(0, 9) != 0);
      x.trans = 2'($urandom_range(0, 9) < 2 ? $urandom_range(0, 1) : $urandom_range(2, 3));
      x.wr    = 1'($urandom);
      x.size  = 3'($urandom_range(0, 19) == 0 ? $urandom_range(3, 7) : $urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:       x.addr = 32'h1000 + 32'($urandom_range(0, 255));
        1:       x.addr = {8'($urandom_range(1, 255)), 24'($urandom_range(0, 255))};
        2:       x.addr = 32'($urandom_range(0, 255));
        default: x.addr = 32'($urandom_range(0, 255)) & ~((32'h1 << x.size) - 32'h1);
      endcase
      x.wdata = $urandom;
      q.push_back(x);
    end
    run_q();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    test_reset();
    test_preload();
    test_word();
    test_byte();
    test_half();
    test_err();
    test_back_to_back();
    test_reset_mid_write();
    test_idle_busy();
    test_random();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
